// File: rtl/gate_lane_if.sv
// Lane-side signal bundle between the loop conditioners / E-pass block and the gate lane controller.
interface gate_lane_if #(
    parameter int unsigned CAP_W  = 8,
    parameter int unsigned TIME_W = 16
);
    logic              sensor1;
    logic              sensor2;
    logic              sensor3;
    logic              epass_valid;
    logic              epass_ok;
    logic              veh_exit;
    logic              calc_req;
    logic              barrier_up;
    logic [TIME_W-1:0] transit_time;
    logic              time_valid;
    logic              reject;
    logic              timeout_err;
    logic [CAP_W-1:0]  occupancy;
    logic              full;
    logic [1:0]        state;

    modport master (
        output sensor1, sensor2, sensor3, epass_valid, epass_ok, veh_exit,
        input  calc_req, barrier_up, transit_time, time_valid, reject, timeout_err,
               occupancy, full, state
    );

    modport slave (
        input  sensor1, sensor2, sensor3, epass_valid, epass_ok, veh_exit,
        output calc_req, barrier_up, transit_time, time_valid, reject, timeout_err,
               occupancy, full, state
    );
endinterface

// File: rtl/gate_lane_controller.sv
// Gate lane controller: times approach-to-reader transit, arbitrates the E-pass verdict,
// drives the barrier and tracks lot occupancy against capacity.
module gate_lane_controller #(
    parameter int unsigned CAP_W         = 8,
    parameter int unsigned CAPACITY      = 200,
    parameter int unsigned TIME_W        = 16,
    parameter int unsigned VALID_TIMEOUT = 1000,
    parameter int unsigned OPEN_TIMEOUT  = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    gate_lane_if.slave bus
);
    localparam int unsigned TMO_MAX = (VALID_TIMEOUT > OPEN_TIMEOUT) ? VALID_TIMEOUT : OPEN_TIMEOUT;
    localparam int unsigned WAIT_W  = $clog2(TMO_MAX + 1);
    localparam logic [WAIT_W-1:0] VALID_LAST = WAIT_W'(VALID_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] OPEN_LAST  = WAIT_W'(OPEN_TIMEOUT - 1);
    localparam logic [CAP_W-1:0]  CAP_VAL    = CAP_W'(CAPACITY);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEASURE  = 2'd1,
        S_VALIDATE = 2'd2,
        S_OPEN     = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [TIME_W-1:0] r_timer, w_timer_nxt, w_timer_inc;
    logic [TIME_W-1:0] r_transit, w_transit_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic [CAP_W-1:0]  r_occ, w_occ_nxt;
    logic              r_full, r_calc_req, r_barrier_up;
    logic              r_time_valid, r_reject, r_timeout_err;
    logic              w_time_valid_nxt, w_reject_nxt, w_timeout_nxt, w_commit;
    logic              r_s1_prev, r_s3_prev;
    logic              w_s1_rise, w_s3_fall;

    assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TIME_W'(1);
    assign w_s1_rise   = bus.sensor1 & ~r_s1_prev;
    assign w_s3_fall   = r_s3_prev & ~bus.sensor3;

    // Next-state, timers and pulse decode
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_transit_nxt    = r_transit;
        w_wait_nxt       = r_wait;
        w_time_valid_nxt = 1'b0;
        w_reject_nxt     = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_commit         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.sensor1 && !r_full) begin
                    w_state_nxt = S_MEASURE;
                    w_timer_nxt = '0;
                end else if (w_s1_rise && r_full) begin
                    w_reject_nxt = 1'b1;
                end
            end
            S_MEASURE: begin
                w_timer_nxt = w_timer_inc;
                if (bus.sensor2) begin
                    w_transit_nxt    = w_timer_inc;
                    w_time_valid_nxt = 1'b1;
                    w_wait_nxt       = '0;
                    w_state_nxt      = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                w_wait_nxt = r_wait + WAIT_W'(1);
                // A verdict on the final cycle takes priority over the timeout
                if (bus.epass_valid) begin
                    if (bus.epass_ok) begin
                        w_state_nxt = S_OPEN;
                        w_wait_nxt  = '0;
                    end else begin
                        w_reject_nxt = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end
                end else if (r_wait == VALID_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_reject_nxt  = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_OPEN: begin
                w_wait_nxt = r_wait + WAIT_W'(1);
                if (w_s3_fall) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait == OPEN_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Occupancy: a simultaneous entry and exit cancel out
    always_comb begin
        w_occ_nxt = r_occ;
        if (w_commit && !bus.veh_exit) begin
            w_occ_nxt = (r_occ >= CAP_VAL) ? r_occ : r_occ + CAP_W'(1);
        end else if (!w_commit && bus.veh_exit && (r_occ != '0)) begin
            w_occ_nxt = r_occ - CAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_transit     <= '0;
            r_wait        <= '0;
            r_occ         <= '0;
            r_full        <= 1'b0;
            r_calc_req    <= 1'b0;
            r_barrier_up  <= 1'b0;
            r_time_valid  <= 1'b0;
            r_reject      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_s1_prev     <= 1'b0;
            r_s3_prev     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_transit     <= w_transit_nxt;
            r_wait        <= w_wait_nxt;
            r_occ         <= w_occ_nxt;
            r_full        <= (r_occ >= CAP_VAL);
            r_calc_req    <= (w_state_nxt == S_VALIDATE);
            r_barrier_up  <= (w_state_nxt == S_OPEN);
            r_time_valid  <= w_time_valid_nxt;
            r_reject      <= w_reject_nxt;
            r_timeout_err <= w_timeout_nxt;
            r_s1_prev     <= bus.sensor1;
            r_s3_prev     <= bus.sensor3;
        end
    end

    assign bus.calc_req     = r_calc_req;
    assign bus.barrier_up   = r_barrier_up;
    assign bus.transit_time = r_transit;
    assign bus.time_valid   = r_time_valid;
    assign bus.reject       = r_reject;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.occupancy    = r_occ;
    assign bus.full         = r_full;
    assign bus.state        = r_state;
endmodule

// File: tb/tb_gate_lane_controller.sv
// Bench for gate_lane_controller: directed scenarios then randomized vehicles against a
// transaction-level model of transit time, verdict outcome and lot occupancy.
module tb_gate_lane_controller;
    localparam int unsigned CAP_W    = 8;
    localparam int unsigned CAPACITY = 2;
    localparam int unsigned TIME_W   = 16;
    localparam int unsigned VT       = 8;
    localparam int unsigned OT       = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    gate_lane_if #(.CAP_W(CAP_W), .TIME_W(TIME_W)) bus ();

    gate_lane_controller #(
        .CAP_W(CAP_W), .CAPACITY(CAPACITY), .TIME_W(TIME_W),
        .VALID_TIMEOUT(VT), .OPEN_TIMEOUT(OT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int occ_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lot count after one cycle, given whether an entry committed and whether a vehicle left
    function automatic int occ_after(input int occ, input bit commit, input bit ex);
        if (commit && ex) return occ;
        if (commit)       return (occ >= int'(CAPACITY)) ? occ : occ + 1;
        if (ex && occ > 0) return occ - 1;
        return occ;
    endfunction

    // One vehicle: sensor2 d2 cycles after entry, verdict on VALIDATE cycle vwait
    // (beyond VT means none), sensor3 falls on OPEN cycle olen (beyond OT means never).
    task automatic vehicle(input int d2, input int vwait, input bit ok, input int olen, input bit ex_same);
        bit full_m;
        full_m = (occ_m >= int'(CAPACITY));
        bus.sensor1 = 1'b1;
        tick();
        bus.sensor1 = 1'b0;
        if (full_m) begin
            chk("full_reject", bus.reject, 1);
            chk("full_stay_idle", bus.state, 0);
            tick();
            chk("reject_one_cycle", bus.reject, 0);
            return;
        end
        chk("enter_measure", bus.state, 1);
        repeat (d2 - 1) tick();
        chk("measure_hold", bus.state, 1);
        bus.sensor2 = 1'b1;
        tick();
        bus.sensor2 = 1'b0;
        chk("transit_time", bus.transit_time, d2);
        chk("time_valid", bus.time_valid, 1);
        chk("calc_req", bus.calc_req, 1);
        if (vwait > int'(VT)) begin
            repeat (VT - 1) tick();
            chk("validate_wait", bus.state, 2);
            chk("time_valid_drop", bus.time_valid, 0);
            tick();
            chk("vto_timeout", bus.timeout_err, 1);
            chk("vto_reject", bus.reject, 1);
            chk("vto_idle", bus.state, 0);
            chk("vto_calc_req", bus.calc_req, 0);
            tick();
            chk("vto_pulse_len", bus.timeout_err, 0);
            return;
        end
        repeat (vwait - 1) tick();
        chk("validate_hold", bus.state, 2);
        bus.epass_valid = 1'b1;
        bus.epass_ok    = ok;
        tick();
        bus.epass_valid = 1'b0;
        bus.epass_ok    = 1'b0;
        chk("verdict_no_timeout", bus.timeout_err, 0);
        if (!ok) begin
            chk("bad_reject", bus.reject, 1);
            chk("bad_idle", bus.state, 0);
            chk("bad_barrier", bus.barrier_up, 0);
            return;
        end
        chk("ok_open", bus.state, 3);
        chk("ok_barrier", bus.barrier_up, 1);
        chk("ok_no_reject", bus.reject, 0);
        bus.sensor3 = 1'b1;
        if (olen > int'(OT)) begin
            repeat (OT - 1) tick();
            chk("open_hold", bus.barrier_up, 1);
            tick();
            chk("oto_timeout", bus.timeout_err, 1);
            chk("oto_no_reject", bus.reject, 0);
            chk("oto_idle", bus.state, 0);
            chk("oto_barrier", bus.barrier_up, 0);
            chk("oto_occupancy", bus.occupancy, occ_m);
            bus.sensor3 = 1'b0;
            return;
        end
        repeat (olen - 1) tick();
        chk("open_wait", bus.state, 3);
        bus.sensor3  = 1'b0;
        bus.veh_exit = ex_same;
        tick();
        bus.veh_exit = 1'b0;
        occ_m = occ_after(occ_m, 1'b1, ex_same);
        chk("commit_idle", bus.state, 0);
        chk("commit_barrier", bus.barrier_up, 0);
        chk("commit_no_timeout", bus.timeout_err, 0);
        chk("commit_occupancy", bus.occupancy, occ_m);
    endtask

    // Idle cycles, optionally with a departure; full is checked once it has settled
    task automatic gap(input bit ex);
        bus.veh_exit = ex;
        tick();
        bus.veh_exit = 1'b0;
        occ_m = occ_after(occ_m, 1'b0, ex);
        tick();
        chk("gap_occupancy", bus.occupancy, occ_m);
        chk("gap_full", bus.full, (occ_m >= int'(CAPACITY)) ? 1 : 0);
        chk("gap_idle", bus.state, 0);
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.sensor1     = 1'b0;
        bus.sensor2     = 1'b0;
        bus.sensor3     = 1'b0;
        bus.epass_valid = 1'b0;
        bus.epass_ok    = 1'b0;
        bus.veh_exit    = 1'b0;
        repeat (3) tick();
        chk("rst_state", bus.state, 0);
        chk("rst_barrier", bus.barrier_up, 0);
        chk("rst_calc_req", bus.calc_req, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_transit", bus.transit_time, 0);
        chk("rst_pulses", {bus.time_valid, bus.reject, bus.timeout_err}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        vehicle(5, 2, 1'b1, 3, 1'b0);          // nominal entry
        gap(1'b0);
        vehicle(3, 1, 1'b0, 3, 1'b0);          // bad pass
        gap(1'b0);
        vehicle(2, VT + 1, 1'b1, 3, 1'b0);     // verdict timeout
        gap(1'b0);
        vehicle(1, VT, 1'b1, OT, 1'b0);        // verdict and exit on last allowed cycles
        gap(1'b0);
        vehicle(4, 1, 1'b1, 3, 1'b0);          // lot full: refused
        gap(1'b1);
        vehicle(2, 1, 1'b1, 2, 1'b1);          // entry and exit together
        gap(1'b1);
        gap(1'b1);                             // exit at zero
        vehicle(3, 3, 1'b1, OT + 1, 1'b0);     // barrier timeout
        gap(1'b0);
        vehicle(2, 1, 1'b1, 2, 1'b0);
        gap(1'b0);

        // Asynchronous reset while the barrier is up
        bus.sensor1 = 1'b1;
        tick();
        bus.sensor1 = 1'b0;
        bus.sensor2 = 1'b1;
        tick();
        bus.sensor2     = 1'b0;
        bus.epass_valid = 1'b1;
        bus.epass_ok    = 1'b1;
        tick();
        bus.epass_valid = 1'b0;
        bus.epass_ok    = 1'b0;
        tick();
        chk("pre_reset_open", bus.barrier_up, 1);
        #2;
        reset_n = 1'b0;
        #2;
        chk("async_rst_barrier", bus.barrier_up, 0);
        chk("async_rst_state", bus.state, 0);
        chk("async_rst_occupancy", bus.occupancy, 0);
        occ_m = 0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 40; i++) begin
            vehicle(int'($urandom_range(1, 6)), int'($urandom_range(1, VT + 1)),
                    ($urandom % 4) != 0, int'($urandom_range(2, OT + 1)), ($urandom % 3) == 0);
            gap(($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
